// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C temperature reader.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK,
    READ,
    MNACK,
    STOP,
    DONE_ST
  } state_e;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam int BIT_W = 3;

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-bit-period timer: counts CLK_DIV cycles per phase, four phases per bit slot.
module i2c_phase_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       run_i,
  input  logic       hold_i,
  output logic       phase_tick_o,
  output logic [1:0] phase_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign phase_tick_o = run_i && !hold_i && (cnt_q == CW'(CLK_DIV - 1));
  assign phase_o      = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = P0;
    end else if (!hold_i) begin
      if (phase_tick_o) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      phase_q <= P0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_temp_reader.sv
// I2C master doing one address + single-byte read per StartReading rise; open-drain pins.
// Optional slave clock stretching is enabled with macro I2C_CLK_STRETCH_EN.
module i2c_temp_reader
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_reading_i,
  input  logic [7:0] first_byte_i,
  input  logic       sda_in_i,
  input  logic       scl_in_i,
  output logic       scl_o,
  output logic       sda_drive_low_o,
  output logic [7:0] rec_data_o,
  output logic       done_o,
  output logic       ack_error_o,
  output logic       busy_o
);

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rec_q, rec_d;
  logic             nack_q, nack_d;
  logic             smp_q, smp_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ackerr_q, ackerr_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;

  logic       run, hold, phase_tick, slot_end, sample, honour, mid;
  logic [1:0] phase;

  assign run = (state_q != IDLE) && (state_q != DONE_ST);

`ifdef I2C_CLK_STRETCH_EN
  // Freeze the phase while a slave holds SCL low against our release.
  assign hold = ((phase == P1) || (phase == P2)) && scl_q && !scl_in_i;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in_i;
  assign hold          = 1'b0;
`endif

  i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .run_i        (run),
    .hold_i       (hold),
    .phase_tick_o (phase_tick),
    .phase_o      (phase)
  );

  assign slot_end = phase_tick && (phase == P3);
  assign sample   = run && (phase == P2) && !smp_q;
  assign mid      = (phase == P1) || (phase == P2);
  assign honour   = start_reading_i && !start_q && !busy_q &&
                    ((state_q == IDLE) || (state_q == DONE_ST));

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    rec_d    = rec_q;
    nack_d   = nack_q;
    smp_d    = smp_q;
    start_d  = start_reading_i;
    busy_d   = busy_q;
    done_d   = done_q;
    ackerr_d = ackerr_q;
    scl_d    = 1'b1;
    sda_d    = 1'b0;

    if (slot_end) smp_d = 1'b0;
    else if (sample) smp_d = 1'b1;

    case (state_q)
      IDLE, DONE_ST: begin
        if (honour) begin
          state_d  = START;
          addr_d   = first_byte_i;
          bit_d    = '0;
          nack_d   = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          ackerr_d = 1'b0;
        end else if (state_q == DONE_ST) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          ackerr_d = nack_q;
          rec_d    = nack_q ? 8'h00 : shift_q;
        end
      end
      START: begin
        scl_d = (phase == P0) || (phase == P1);
        sda_d = 1'b1;
        if (slot_end) state_d = ADDR;
      end
      ADDR: begin
        scl_d = mid;
        sda_d = ~addr_q[3'd7 - bit_q];
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ACK;
        end
      end
      ACK: begin
        scl_d = mid;
        if (sample) nack_d = sda_in_i;
        if (slot_end) state_d = nack_q ? STOP : READ;
      end
      READ: begin
        scl_d = mid;
        if (sample) shift_d = {shift_q[6:0], sda_in_i};
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = MNACK;
        end
      end
      MNACK: begin
        scl_d = mid;
        if (slot_end) state_d = STOP;
      end
      STOP: begin
        // SDA low first, then SCL high, then SDA released while SCL is high.
        scl_d = (phase != P0);
        sda_d = (phase == P0) || (phase == P1);
        if (slot_end) state_d = DONE_ST;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      addr_q   <= '0;
      shift_q  <= '0;
      rec_q    <= '0;
      nack_q   <= 1'b0;
      smp_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ackerr_q <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
      rec_q    <= rec_d;
      nack_q   <= nack_d;
      smp_q    <= smp_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ackerr_q <= ackerr_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
    end
  end

  assign scl_o           = scl_q;
  assign sda_drive_low_o = sda_q;
  assign rec_data_o      = rec_q;
  assign done_o          = done_q;
  assign ack_error_o     = ackerr_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_i2c_temp_reader.sv
// Bench for i2c_temp_reader: open-drain slave at 0x91 returning 0x19, transaction-level model.
module tb_i2c_temp_reader;

  localparam int CD = 2;
  localparam logic [7:0] SLAVE_ADDR = 8'h91;
  localparam logic [7:0] SLAVE_DATA = 8'h19;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH = 10;
`else
  localparam int STRETCH = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] fbyte = 8'h00;
  logic       scl, sda_low, done, ackerr, busy;
  logic [7:0] rec;
  logic       slave_low = 1'b0;
  logic       stretch_low = 1'b0;
  logic       sda_line, scl_line;

  assign sda_line = !sda_low && !slave_low;
  assign scl_line = scl && !stretch_low;

  always #5 clk = ~clk;

  i2c_temp_reader #(.CLK_DIV(CD)) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .start_reading_i (start),
    .first_byte_i    (fbyte),
    .sda_in_i        (sda_line),
    .scl_in_i        (scl_line),
    .scl_o           (scl),
    .sda_drive_low_o (sda_low),
    .rec_data_o      (rec),
    .done_o          (done),
    .ack_error_o     (ackerr),
    .busy_o          (busy)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a honoured rise produces a result a fixed
  // number of bit slots later; the result depends only on the address byte.
  int         cyc = 0;
  int         due = 0;
  bit         m_busy = 0, m_done = 0, m_ackerr = 0, m_rise = 0;
  logic [7:0] m_rec = 8'h00, m_addr = 8'h00;
  logic       start_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_done = 0; m_ackerr = 0; m_rec = 8'h00; start_prev = 1'b0;
    end else begin
      m_rise = start && !start_prev;
      if (m_busy && cyc == due) begin
        m_busy   = 0;
        m_done   = 1;
        m_ackerr = (m_addr != SLAVE_ADDR);
        m_rec    = m_ackerr ? 8'h00 : SLAVE_DATA;
      end else if (m_rise && !m_busy) begin
        m_busy   = 1;
        m_done   = 0;
        m_ackerr = 0;
        m_addr   = fbyte;
        if (fbyte == SLAVE_ADDR) due = cyc + 20 * 4 * CD + 1 + STRETCH;
        else due = cyc + 11 * 4 * CD + 1;
      end
      start_prev = start;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("done_vs_model", done, m_done);
      check("busy_vs_model", busy, m_busy);
      if (m_done) begin
        check("rec_vs_model", rec, m_rec);
        check("ackerr_vs_model", ackerr, m_ackerr);
      end
    end
  end

  // Open-drain slave: decodes START/STOP and bits from the bus lines.
  int         nrise = 0, n_start = 0, n_stop = 0, st_cnt = 0;
  logic [7:0] sh = 8'h00, seen_addr = 8'h00;
  logic [7:0] sdata = SLAVE_DATA;
  bit         acked = 0, seen_nack = 0;
  logic       scl_p = 1'b1, sda_p = 1'b1, scl_o_p = 1'b1, sl, sd;

  always @(negedge clk) begin
    if (rst) begin
      slave_low = 1'b0; stretch_low = 1'b0; nrise = 0; acked = 0;
    end else begin
`ifdef I2C_CLK_STRETCH_EN
      if (stretch_low) begin
        st_cnt++;
        if (st_cnt >= STRETCH) stretch_low = 1'b0;
      end else if (scl && !scl_o_p && nrise == 8 && acked) begin
        stretch_low = 1'b1;
        st_cnt = 0;
      end
`endif
      sl = scl && !stretch_low;
      sd = !sda_low && !slave_low;
      if (sl && scl_p && sda_p && !sd) begin
        n_start++; nrise = 0; acked = 0; slave_low = 1'b0;
      end else if (sl && scl_p && !sda_p && sd) begin
        n_stop++; nrise = 0;
      end else if (sl && !scl_p) begin
        if (nrise < 8) sh = {sh[6:0], sd};
        if (nrise == 17) seen_nack = sd;
        nrise++;
        if (nrise == 8) seen_addr = sh;
      end else if (!sl && scl_p) begin
        if (nrise == 8) begin
          acked = (sh == SLAVE_ADDR);
          slave_low = acked;
        end else if (nrise >= 9 && nrise <= 16) begin
          slave_low = acked && !sdata[16 - nrise];
        end else begin
          slave_low = 1'b0;
        end
      end
    end
    scl_o_p = scl;
    scl_p   = scl && !stretch_low;
    sda_p   = !sda_low && !slave_low;
  end

  task automatic do_read(input logic [7:0] a, input bit keep_high, input int bounce_at,
                         output int lat);
    start = 1'b0;
    @(posedge clk); #1;
    fbyte = a;
    start = 1'b1;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (bounce_at != 0 && lat == bounce_at) start = 1'b0;
      if (bounce_at != 0 && lat == bounce_at + 2) start = 1'b1;
      if (done) break;
      if (lat > 3000) begin
        check("read_timeout", 32'(done), 32'd1);
        break;
      end
    end
    if (!keep_high) start = 1'b0;
  endtask

  initial begin
    int lat, s0, p0, k;
    logic [7:0] a;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_scl", scl, 1);
    check("rst_sda", sda_low, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rec", rec, 0);
    check("rst_ackerr", ackerr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // acknowledged read
    s0 = n_start; p0 = n_stop;
    do_read(8'h91, 0, 0, lat);
    check("ack_latency", lat, 162 + STRETCH);
    check("ack_rec", rec, 8'h19);
    check("ack_ackerr", ackerr, 0);
    check("ack_busy", busy, 0);
    check("ack_bus_addr", seen_addr, 8'h91);
    check("ack_bus_mnack", 32'(seen_nack), 1);
    check("ack_bus_starts", n_start - s0, 1);
    check("ack_bus_stops", n_stop - p0, 1);

    // nobody answers
    s0 = n_start; p0 = n_stop;
    do_read(8'h93, 0, 0, lat);
    check("nack_latency", lat, 90);
    check("nack_ackerr", ackerr, 1);
    check("nack_rec", rec, 8'h00);
    check("nack_bus_addr", seen_addr, 8'h93);
    check("nack_bus_stops", n_stop - p0, 1);
    check("nack_bus_starts", n_start - s0, 1);

    // StartReading held high through and after completion
    s0 = n_start;
    do_read(8'h91, 1, 0, lat);
    check("held_latency", lat, 162 + STRETCH);
    repeat (40) @(posedge clk);
    #1;
    check("held_done_sticky", done, 1);
    check("held_one_txn", n_start - s0, 1);
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    check("rerise_done_clear", done, 0);
    check("rerise_busy", busy, 1);
    k = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check("rerise_done", done, 1);
    check("rerise_rec", rec, 8'h19);
    start = 1'b0;

    // extra rise while busy is ignored
    s0 = n_start;
    do_read(8'h91, 0, 50, lat);
    check("bounce_latency", lat, 162 + STRETCH);
    check("bounce_one_txn", n_start - s0, 1);
    check("bounce_rec", rec, 8'h19);

    // reset during READ bit 3
    start = 1'b0;
    @(posedge clk); #1;
    fbyte = 8'h91;
    start = 1'b1;
    repeat (108 + STRETCH) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midrst_scl", scl, 1);
    check("midrst_sda", sda_low, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(8'h91, 0, 0, lat);
    check("post_rst_latency", lat, 162 + STRETCH);
    check("post_rst_rec", rec, 8'h19);

    // randomized requests
    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 8'h91 : 8'($urandom_range(0, 255));
      s0 = n_start;
      start = 1'b0;
      fbyte = a;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      start = 1'b1;
      repeat ($urandom_range(1, 60)) @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b0;
        fbyte = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        start = 1'b1;
      end
      k = 0;
      while (!done && k < 3000) begin
        @(posedge clk); #1;
        k++;
      end
      check("rand_done", done, 1);
      check("rand_rec", rec, (a == 8'h91) ? 8'h19 : 8'h00);
      check("rand_ackerr", ackerr, (a == 8'h91) ? 32'd0 : 32'd1);
      check("rand_bus_addr", seen_addr, a);
      check("rand_one_txn", n_start - s0, 1);
      if ($urandom_range(0, 1) == 1) start = 1'b0;
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

endmodule
